// File: rtl/key_mmio_ctrl_pkg.sv
// Shared constants for the KEY push-button MMIO window: register indices,
// window base used by the MEM stage for its select decode, and register width.
package key_mmio_ctrl_pkg;

    localparam int unsigned KEY_REG_W = 32;

    localparam logic [1:0] KEY_IDX_DATA = 2'd0;
    localparam logic [1:0] KEY_IDX_EDGE = 2'd1;
    localparam logic [1:0] KEY_IDX_IE   = 2'd2;
    localparam logic [1:0] KEY_IDX_OVR  = 2'd3;

    localparam logic [31:0] KEY_BASE_ADDR = 32'hFF20_0050;
    localparam logic [31:0] KEY_WIN_MASK  = 32'hFFFF_FFF0;

    // MEM-stage window decode: four word registers at KEY_BASE_ADDR.
    function automatic logic key_window_hit(input logic [31:0] addr);
        return (addr & KEY_WIN_MASK) == KEY_BASE_ADDR;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: two-flop synchroniser, hold-time debouncer and press pulse.
// press_evt fires in the cycle whose clock edge moves stable from 0 to 1.
module key_debounce
    import key_mmio_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic stable,
    output logic press_evt
);

    logic             meta;
    logic             sync_q;
    logic             sync;
    logic             accept;
    logic [CNT_W-1:0] cnt;

    // Synchroniser resets to the released level.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta   <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta   <= key_n;
            sync_q <= meta;
        end
    end

    assign sync   = ~sync_q;
    assign accept = (sync != stable) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    // Any return to the accepted level restarts the hold count.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (sync == stable) begin
            cnt    <= '0;
        end else if (accept) begin
            stable <= sync;
            cnt    <= '0;
        end else begin
            cnt    <= cnt + CNT_W'(1);
        end
    end

    assign press_evt = accept & sync;

endmodule

// File: rtl/key_mmio_ctrl.sv
// KEY MMIO controller: debounced button state, sticky press/overrun flags,
// interrupt enables and a single-cycle register port for the MEM stage.
module key_mmio_ctrl
    import key_mmio_ctrl_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_KEYS-1:0]  key_n,
    input  logic                 sel,
    input  logic                 wr_en,
    input  logic [1:0]           reg_idx,
    input  logic [KEY_REG_W-1:0] wr_data,
    output logic [KEY_REG_W-1:0] rd_data,
    output logic                 key_irq
);

    logic [NUM_KEYS-1:0] stable;
    logic [NUM_KEYS-1:0] press_evt;
    logic [NUM_KEYS-1:0] kedge;
    logic [NUM_KEYS-1:0] kie;
    logic [NUM_KEYS-1:0] kovr;
    logic [NUM_KEYS-1:0] clr_edge;
    logic [NUM_KEYS-1:0] clr_ovr;
    logic                wr_hit;
    logic                unused_wr_hi;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk      (clk),
            .reset    (reset),
            .key_n    (key_n[gi]),
            .stable   (stable[gi]),
            .press_evt(press_evt[gi])
        );
    end

    assign wr_hit       = sel & wr_en;
    assign clr_edge     = (wr_hit && reg_idx == KEY_IDX_EDGE) ? wr_data[NUM_KEYS-1:0] : '0;
    assign clr_ovr      = (wr_hit && reg_idx == KEY_IDX_OVR)  ? wr_data[NUM_KEYS-1:0] : '0;
    assign unused_wr_hi = ^wr_data[KEY_REG_W-1:NUM_KEYS];

    // Sticky flags: a new press always wins over a same-cycle W1C.
    always_ff @(posedge clk) begin
        if (reset) begin
            kedge <= '0;
            kie   <= '0;
            kovr  <= '0;
        end else begin
            kedge <= (kedge & ~clr_edge) | press_evt;
            kovr  <= (kovr & ~clr_ovr) | (press_evt & kedge & ~clr_edge);
            if (wr_hit && reg_idx == KEY_IDX_IE) begin
                kie <= wr_data[NUM_KEYS-1:0];
            end
        end
    end

    // Side-effect-free read mux, showing pre-update register values.
    always_comb begin
        rd_data = '0;
        if (sel && !wr_en && !reset) begin
            case (reg_idx)
                KEY_IDX_DATA: rd_data = KEY_REG_W'(stable);
                KEY_IDX_EDGE: rd_data = KEY_REG_W'(kedge);
                KEY_IDX_IE:   rd_data = KEY_REG_W'(kie);
                default:      rd_data = KEY_REG_W'(kovr);
            endcase
        end
    end

    assign key_irq = |(kedge & kie);

endmodule

// File: tb/tb_key_mmio_ctrl.sv
// Bench for key_mmio_ctrl: directed latency checks plus randomized buttons,
// register traffic and resets, compared every cycle against a reference model.
module tb_key_mmio_ctrl;

    localparam int unsigned NK = 4;
    localparam int unsigned DB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] key_n;
    logic          sel;
    logic          wr_en;
    logic [1:0]    reg_idx;
    logic [31:0]   wr_data;
    logic [31:0]   rd_data;
    logic          key_irq;

    int checks   = 0;
    int failures = 0;

    key_mmio_ctrl #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .key_n  (key_n),
        .sel    (sel),
        .wr_en  (wr_en),
        .reg_idx(reg_idx),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .key_irq(key_irq)
    );

    always #5 clk = ~clk;

    // Reference state: accepted levels and the three software-visible registers.
    logic [NK-1:0] m_stable = '0;
    logic [NK-1:0] m_kedge  = '0;
    logic [NK-1:0] m_kie    = '0;
    logic [NK-1:0] m_kovr   = '0;
    logic [NK-1:0] raw_q[$];
    logic [NK-1:0] win[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Button levels reach the debouncer two edges late; a level is accepted once
    // the last DB delayed samples all disagree with the currently accepted level.
    task automatic model_edge(input logic r, input logic [NK-1:0] kn, input logic s,
                              input logic w, input logic [1:0] idx, input logic [31:0] wd);
        logic [NK-1:0] sync_now, new_stable, press, clr_e, clr_o, ovr_set;
        bit all_diff;
        if (r) begin
            m_stable = '0; m_kedge = '0; m_kie = '0; m_kovr = '0;
            raw_q.delete(); raw_q.push_back('0); raw_q.push_back('0);
            win.delete();
        end else begin
            raw_q.push_back(~kn);
            sync_now = raw_q.pop_front();
            win.push_back(sync_now);
            if (win.size() > DB) void'(win.pop_front());
            new_stable = m_stable;
            if (win.size() == DB) begin
                for (int i = 0; i < NK; i++) begin
                    all_diff = 1'b1;
                    foreach (win[k]) if (win[k][i] == m_stable[i]) all_diff = 1'b0;
                    if (all_diff) new_stable[i] = ~m_stable[i];
                end
            end
            press   = new_stable & ~m_stable;
            clr_e   = (s && w && idx == 2'd1) ? wd[NK-1:0] : '0;
            clr_o   = (s && w && idx == 2'd3) ? wd[NK-1:0] : '0;
            ovr_set = press & m_kedge & ~clr_e;
            m_kedge = (m_kedge & ~clr_e) | press;
            m_kovr  = (m_kovr & ~clr_o) | ovr_set;
            if (s && w && idx == 2'd2) m_kie = wd[NK-1:0];
            m_stable = new_stable;
        end
    endtask

    // One clock: drive on the falling edge, check, then advance the model.
    task automatic step(input logic r, input logic [NK-1:0] kn, input logic s, input logic w,
                        input logic [1:0] idx, input logic [31:0] wd, output logic [31:0] seen);
        logic [31:0] exp_rd;
        @(negedge clk);
        reset = r; key_n = kn; sel = s; wr_en = w; reg_idx = idx; wr_data = wd;
        #1;
        exp_rd = '0;
        if (s && !w && !r) begin
            case (idx)
                2'd0: exp_rd = 32'(m_stable);
                2'd1: exp_rd = 32'(m_kedge);
                2'd2: exp_rd = 32'(m_kie);
                default: exp_rd = 32'(m_kovr);
            endcase
        end
        seen = rd_data;
        check("rd_data", rd_data, exp_rd);
        check("key_irq", 32'(key_irq), 32'(|(m_kedge & m_kie)));
        @(posedge clk);
        model_edge(r, kn, s, w, idx, wd);
    endtask

    initial begin
        logic [31:0]   rd;
        logic [NK-1:0] kn;
        int            lat;

        reset = 1'b1; key_n = '0; sel = 1'b1; wr_en = 1'b0; reg_idx = 2'd0; wr_data = '0;
        @(posedge clk);
        model_edge(1'b1, '0, 1'b0, 1'b0, 2'd0, '0);

        // Reset held with all keys down: reads blocked, then press seen 6 edges later.
        for (int j = 0; j < 3; j++) step(1'b1, '0, 1'b1, 1'b0, 2'(j), '0, rd);
        lat = -1;
        for (int j = 0; j < 20; j++) begin
            step(1'b0, '0, 1'b1, 1'b0, 2'd0, '0, rd);
            if (rd == 32'hF && lat < 0) lat = j;
        end
        check("rst_press_lat", 32'(lat), 32'd6);
        step(1'b0, '0, 1'b1, 1'b0, 2'd1, '0, rd);
        check("rst_kedge", rd, 32'hF);

        // Release everything, clear flags, then a clean press on key1.
        step(1'b0, 4'hF, 1'b1, 1'b1, 2'd1, 32'hF, rd);
        for (int j = 0; j < 12; j++) step(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, '0, rd);
        lat = -1;
        for (int j = 0; j < 20; j++) begin
            step(1'b0, 4'b1101, 1'b1, 1'b0, 2'd1, '0, rd);
            if (rd[1] && lat < 0) lat = j;
        end
        check("press_lat", 32'(lat), 32'd6);
        step(1'b0, 4'b1101, 1'b1, 1'b0, 2'd0, '0, rd);
        check("press_kdata", rd, 32'h2);

        // Randomized buttons with bounces, register traffic and rare resets.
        kn = 4'hF;
        for (int c = 0; c < 4000; c++) begin
            logic       r, s, w;
            logic [1:0] idx;
            logic [31:0] wd;
            for (int i = 0; i < NK; i++) if ($urandom_range(0, 6) == 0) kn[i] = ~kn[i];
            r   = ($urandom_range(0, 299) == 0);
            s   = $urandom_range(0, 1) == 1;
            w   = $urandom_range(0, 3) == 0;
            idx = 2'($urandom_range(0, 3));
            wd  = $urandom();
            if (idx == 2'd1 && $urandom_range(0, 1) == 1) wd = '0;
            step(r, kn, s, w, idx, wd, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
